// File: rtl/misr_pkg.sv
// rtl/misr_pkg.sv - shared types, defaults and the MISR step function
package misr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } misr_state_t;

  localparam logic [31:0] DEFAULT_POLY32 = 32'h04C11DB7;
  localparam int          MISR_MAX_W     = 64;

  // Galois step on a register of `width` bits (width <= MISR_MAX_W), zero-extended operands
  function automatic logic [MISR_MAX_W-1:0] misr_step(
    input logic [MISR_MAX_W-1:0] r,
    input logic [MISR_MAX_W-1:0] din,
    input logic [MISR_MAX_W-1:0] poly,
    input int                    width
  );
    logic [MISR_MAX_W-1:0] mask;
    logic [MISR_MAX_W-1:0] nxt;
    mask = (width >= MISR_MAX_W) ? '1 : ((MISR_MAX_W'(1) << width) - MISR_MAX_W'(1));
    nxt  = (r << 1) ^ din;
    if (r[width-1]) nxt = nxt ^ poly;
    return nxt & mask;
  endfunction

endpackage

// File: rtl/misr_lane.sv
// rtl/misr_lane.sv - one MISR lane register with seed load and compaction step
module misr_lane
  import misr_pkg::*;
#(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] POLY  = DEFAULT_POLY32[WIDTH-1:0],
  parameter logic [WIDTH-1:0] SEED  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] r
);

  // load wins over step; the top never asserts both in one cycle anyway
  always_ff @(posedge clk) begin
    if (rst) begin
      r <= '0;
    end else if (load) begin
      r <= SEED;
    end else if (step) begin
      r <= WIDTH'(misr_step(MISR_MAX_W'(r), MISR_MAX_W'(din), MISR_MAX_W'(POLY), WIDTH));
    end
  end

endmodule

// File: rtl/misr_compactor.sv
// rtl/misr_compactor.sv - multi-lane MISR with run FSM and golden compare; MISR_XMASK_EN adds lane_mask
module misr_compactor
  import misr_pkg::*;
#(
  parameter int               WIDTH  = 32,
  parameter int               NUM_CH = 4,
  parameter logic [WIDTH-1:0] POLY   = DEFAULT_POLY32[WIDTH-1:0],
  parameter logic [WIDTH-1:0] SEED   = '0,
  parameter int               CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [CNT_W-1:0]        num_patterns,
  input  logic [WIDTH-1:0]        golden,
  input  logic                    resp_valid,
  input  logic [NUM_CH*WIDTH-1:0] resp_data,
`ifdef MISR_XMASK_EN
  input  logic [NUM_CH-1:0]       lane_mask,
`endif
  output logic                    resp_ready,
  output logic [WIDTH-1:0]        signature,
  output logic [CNT_W-1:0]        pattern_cnt,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic                    fail
);

  misr_state_t      state;
  logic [CNT_W-1:0] target;
  logic [CNT_W-1:0] cnt_inc;
  logic             done_q;
  logic             pass_q;
  logic             fail_q;
  logic             accept;
  logic             load;
  logic             match;

  logic [WIDTH-1:0] lane_din [NUM_CH];
  logic [WIDTH-1:0] lane_r   [NUM_CH];

  assign accept  = resp_valid && (state == RUN) && !abort;
  assign load    = start && !abort && (state != RUN);
  assign cnt_inc = pattern_cnt + CNT_W'(1);

  genvar k;
  generate
    for (k = 0; k < NUM_CH; k++) begin : g_lane
`ifdef MISR_XMASK_EN
      assign lane_din[k] = lane_mask[k] ? '0 : resp_data[k*WIDTH +: WIDTH];
`else
      assign lane_din[k] = resp_data[k*WIDTH +: WIDTH];
`endif
      misr_lane #(
        .WIDTH(WIDTH),
        .POLY (POLY),
        .SEED (SEED)
      ) u_lane (
        .clk (clk),
        .rst (rst),
        .load(load),
        .step(accept),
        .din (lane_din[k]),
        .r   (lane_r[k])
      );
    end
  endgenerate

  always_comb begin
    signature = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      signature = signature ^ lane_r[i];
    end
  end

  assign match = (signature == golden);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pattern_cnt <= '0;
      target      <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort) begin
        state  <= IDLE;
        pass_q <= 1'b0;
        fail_q <= 1'b0;
      end else begin
        case (state)
          IDLE, DONE: begin
            // verdict is frozen from the first DONE cycle; a restart then clears it
            if (done_q) begin
              pass_q <= match;
              fail_q <= !match;
            end
            if (start) begin
              pattern_cnt <= '0;
              target      <= num_patterns;
              pass_q      <= 1'b0;
              fail_q      <= 1'b0;
              if (num_patterns == '0) begin
                state  <= DONE;
                done_q <= 1'b1;
              end else begin
                state <= RUN;
              end
            end
          end
          RUN: begin
            if (accept) begin
              pattern_cnt <= cnt_inc;
              if (cnt_inc == target) begin
                state  <= DONE;
                done_q <= 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign resp_ready = (state == RUN);
  assign busy       = (state == RUN);
  assign done       = done_q;
  assign pass       = done_q ? match  : pass_q;
  assign fail       = done_q ? !match : fail_q;

endmodule
